systolic_writeback: RTL and testbench

- Drain/writeback engine on the output side of the systolic MAC array.
- After the array has finished accumulating, it steps the array's `matrix_index` select and reads back the 8 diagonal result slices.
- Each 21-bit signed accumulator is requantized to 8-bit signed: arithmetic shift, round-half-up, saturate.
- Bytes are packed into two 32-bit output SRAM banks, using the same byte order the array uses on its input banks.

---
 rtl/systolic_pkg.sv | 37 +++
 rtl/systolic_writeback_if.sv | 29 ++
 rtl/systolic_requant.sv | 44 ++++
 rtl/systolic_writeback.sv | 107 ++++++++++
 tb/tb_systolic_writeback.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array and its writeback engine.
// Holds array geometry, requant saturation bounds, drain FSM encoding and the
// byte-lane packing used on both input and output SRAM banks.
package systolic_pkg;

  localparam int ARRAY_SIZE      = 8;
  localparam int DATA_WIDTH      = 8;
  localparam int OUTCOME_WIDTH   = 2 * DATA_WIDTH + 5;
  localparam int SRAM_DATA_WIDTH = 32;
  localparam int ADDR_WIDTH      = 10;
  localparam int IDX_WIDTH       = 6;
  localparam int SHIFT_WIDTH     = 5;
  localparam int LANES           = SRAM_DATA_WIDTH / DATA_WIDTH;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    FIN   = 2'd3
  } state_t;

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] lanes_t;

  // Element 0 lands in the most significant byte, element LANES-1 in the least.
  function automatic logic [SRAM_DATA_WIDTH-1:0] pack_lanes(input lanes_t elems);
    logic [SRAM_DATA_WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < LANES; i++) begin
      w[SRAM_DATA_WIDTH-1-DATA_WIDTH*i -: DATA_WIDTH] = elems[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/systolic_writeback_if.sv
// Bundle between the writeback engine, its controller, the MAC array and the
// output SRAM banks. slave = the engine, master = everything around it.
// Write bus signals are common to both output banks.
interface systolic_writeback_if
  import systolic_pkg::*;
  ;
  logic                                 start;
  logic [ADDR_WIDTH-1:0]                base_addr;
  logic [SHIFT_WIDTH-1:0]               shift_amt;
  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0]  mul_outcome;
  logic [IDX_WIDTH-1:0]                 matrix_index;
  logic                                 sram_wen;
  logic [ADDR_WIDTH-1:0]                sram_waddr;
  logic [SRAM_DATA_WIDTH-1:0]           sram_wdata0;
  logic [SRAM_DATA_WIDTH-1:0]           sram_wdata1;
  logic                                 busy;
  logic                                 done;

  modport slave (
    input  start, base_addr, shift_amt, mul_outcome,
    output matrix_index, sram_wen, sram_waddr, sram_wdata0, sram_wdata1, busy, done
  );

  modport master (
    output start, base_addr, shift_amt, mul_outcome,
    input  matrix_index, sram_wen, sram_waddr, sram_wdata0, sram_wdata1, busy, done
  );

endinterface

// File: rtl/systolic_requant.sv
// Requantizes one signed accumulator to a signed byte: shift, round-half-up, saturate.
// Latency: purely combinational.
// Backpressure: none.
module systolic_requant
  import systolic_pkg::*;
(
  input  logic [OUTCOME_WIDTH-1:0] x,
  input  logic [SHIFT_WIDTH-1:0]   shift,
  output logic [DATA_WIDTH-1:0]    y
);

  // One guard bit so the rounding add never wraps.
  localparam int EXT_W = OUTCOME_WIDTH + 1;
  localparam logic signed [EXT_W-1:0]       MAX_W     = EXT_W'(SAT_MAX);
  localparam logic signed [EXT_W-1:0]       MIN_W     = EXT_W'(SAT_MIN);
  localparam logic [SHIFT_WIDTH-1:0]        SHIFT_LIM = SHIFT_WIDTH'(OUTCOME_WIDTH);

  logic signed [EXT_W-1:0] xe;
  logic signed [EXT_W-1:0] rnd;
  logic signed [EXT_W-1:0] shifted;

  // Round, shift, then clamp into the signed byte range.
  always_comb begin
    xe  = $signed({x[OUTCOME_WIDTH-1], x});
    rnd = '0;
    if (shift != '0) begin
      rnd = EXT_W'(1) << (shift - SHIFT_WIDTH'(1));
    end
    // Shifting out every magnitude bit leaves only the sign.
    if (shift >= SHIFT_LIM) begin
      shifted = x[OUTCOME_WIDTH-1] ? '1 : '0;
    end else begin
      shifted = (xe + rnd) >>> shift;
    end
    if (shifted > MAX_W) begin
      y = MAX_W[DATA_WIDTH-1:0];
    end else if (shifted < MIN_W) begin
      y = MIN_W[DATA_WIDTH-1:0];
    end else begin
      y = shifted[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/systolic_writeback.sv
// Drains the 8 diagonal result slices of the MAC array, requantizes and writes them to two SRAM banks.
// Latency: start in cycle 0 -> writes in cycles 2..9 -> done pulse in cycle 10.
// Backpressure: none; start is ignored while busy, SRAM writes are unconditional.
module systolic_writeback
  import systolic_pkg::*;
(
  input  logic                 clk,
  input  logic                 srstn,
  systolic_writeback_if.slave  bus
);

  localparam int              K_W    = $clog2(ARRAY_SIZE);
  localparam logic [K_W-1:0]  K_LAST = K_W'(ARRAY_SIZE - 1);

  state_t                       state;
  logic [K_W-1:0]               k;
  logic [ADDR_WIDTH-1:0]        base_q;
  logic [SHIFT_WIDTH-1:0]       shift_q;
  logic                         wen_q;
  logic [ADDR_WIDTH-1:0]        waddr_q;
  logic [SRAM_DATA_WIDTH-1:0]   wdata0_q;
  logic [SRAM_DATA_WIDTH-1:0]   wdata1_q;
  logic                         busy_q;
  logic                         done_q;

  logic [DATA_WIDTH-1:0]        q_elem [ARRAY_SIZE];
  lanes_t                       lanes0;
  lanes_t                       lanes1;

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_requant
    systolic_requant u_requant (
      .x     (bus.mul_outcome[g*OUTCOME_WIDTH +: OUTCOME_WIDTH]),
      .shift (shift_q),
      .y     (q_elem[g])
    );
  end

  // Rows 0..3 go to bank 0, rows 4..7 to bank 1.
  always_comb begin
    lanes0 = '0;
    lanes1 = '0;
    for (int i = 0; i < LANES; i++) begin
      lanes0[i] = q_elem[i];
      lanes1[i] = q_elem[i + LANES];
    end
  end

  // Drain FSM, slice counter and the single write pipeline register.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state    <= IDLE;
      k        <= '0;
      base_q   <= '0;
      shift_q  <= '0;
      wen_q    <= 1'b1;
      waddr_q  <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wen_q  <= 1'b1;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            base_q  <= bus.base_addr;
            shift_q <= bus.shift_amt;
            k       <= '0;
            busy_q  <= 1'b1;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          // The slice selected by k this cycle is written out next cycle.
          wen_q    <= 1'b0;
          waddr_q  <= base_q + ADDR_WIDTH'(k);
          wdata0_q <= pack_lanes(lanes0);
          wdata1_q <= pack_lanes(lanes1);
          k        <= k + K_W'(1);
          if (k == K_LAST) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          done_q <= 1'b1;
          state  <= FIN;
        end
        FIN: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // k wraps back to zero after the last slice, so the select idles at 0.
  assign bus.matrix_index = {{(IDX_WIDTH-K_W){1'b0}}, k};
  assign bus.sram_wen     = wen_q;
  assign bus.sram_waddr   = waddr_q;
  assign bus.sram_wdata0  = wdata0_q;
  assign bus.sram_wdata1  = wdata1_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_systolic_writeback.sv
// Self-checking bench for systolic_writeback: directed literal cases plus randomized jobs,
// all checked every cycle against a job-timeline model with an integer requant reference.
module tb_systolic_writeback;

  logic clk = 1'b0;
  logic srstn = 1'b0;

  systolic_writeback_if bus ();

  systolic_writeback dut (
    .clk   (clk),
    .srstn (srstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Array contents: mat[row][col]; slice k returns column (k-row) mod 8 for each row.
  logic signed [20:0] mat [8][8];

  always_comb begin
    bus.mul_outcome = '0;
    for (int i = 0; i < 8; i++) begin
      bus.mul_outcome[i*21 +: 21] = mat[i][(int'(bus.matrix_index) - i) & 7];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model state: position within the current job (cycle 0 = start cycle), -1 when idle.
  int job_t   = -1;
  int m_base  = 0;
  int m_shift = 0;

  // Captures for directed checks.
  int wr_cnt = 0;
  int done_cnt = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  logic [31:0] first_d0, first_d1;
  int addr_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rq(input int x, input int s);
    int y;
    if (s == 0) y = x;
    else if (s >= 21) y = (x < 0) ? -1 : 0;
    else y = (x + (1 << (s - 1))) >>> s;
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return y;
  endfunction

  function automatic logic [31:0] exp_word(input int k, input int half);
    logic [31:0] w;
    int y;
    w = '0;
    for (int r = 0; r < 4; r++) begin
      int row;
      row = half * 4 + r;
      y = rq(int'(mat[row][(k - row) & 7]), m_shift);
      w[31 - 8*r -: 8] = y[7:0];
    end
    return w;
  endfunction

  always @(posedge clk) cyc++;

  // Job timeline model.
  always @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      job_t = -1;
    end else if (job_t >= 1) begin
      job_t = (job_t == 10) ? -1 : job_t + 1;
    end else if (bus.start) begin
      job_t   = 1;
      m_base  = int'(bus.base_addr);
      m_shift = int'(bus.shift_amt);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    bit exp_busy, exp_done, exp_wr;
    int exp_idx;
    exp_busy = srstn && job_t >= 1 && job_t <= 10;
    exp_done = srstn && job_t == 10;
    exp_wr   = srstn && job_t >= 2 && job_t <= 9;
    exp_idx  = (srstn && job_t >= 1 && job_t <= 8) ? job_t - 1 : 0;
    check("busy", 64'(bus.busy), 64'(exp_busy));
    check("done", 64'(bus.done), 64'(exp_done));
    check("sram_wen", 64'(bus.sram_wen), 64'(!exp_wr));
    check("matrix_index", 64'(bus.matrix_index), 64'(exp_idx));
    if (exp_wr) begin
      check("sram_waddr", 64'(bus.sram_waddr), 64'((m_base + job_t - 2) % 1024));
      check("sram_wdata0", 64'(bus.sram_wdata0), 64'(exp_word(job_t - 2, 0)));
      check("sram_wdata1", 64'(bus.sram_wdata1), 64'(exp_word(job_t - 2, 1)));
    end
    if (srstn && !bus.sram_wen) begin
      wr_cnt++;
      if (wr_cnt == 1) begin
        first_d0 = bus.sram_wdata0;
        first_d1 = bus.sram_wdata1;
        first_wr_cyc = cyc;
      end
      last_wr_cyc = cyc;
      addr_q.push_back(int'(bus.sram_waddr));
    end
    if (srstn && bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_caps();
    wr_cnt = 0;
    done_cnt = 0;
    addr_q.delete();
  endtask

  task automatic fill_rows(input int v0, v1, v2, v3, v4, v5, v6, v7);
    int v[8];
    v = '{v0, v1, v2, v3, v4, v5, v6, v7};
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        mat[i][j] = 21'(v[i]);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        case ($urandom_range(0, 2))
          0: mat[i][j] = 21'(int'($urandom_range(0, 600)) - 300);
          1: mat[i][j] = 21'($urandom);
          default: mat[i][j] = ($urandom_range(0, 1) == 1) ? 21'h0FFFFF : 21'h100000;
        endcase
      end
    end
  endtask

  // Called at #1 into cycle 0; returns at #1 into cycle 11. extra>0 pulses start in that cycle.
  task automatic job_body(input int base, input int shift, input int extra);
    bus.start = 1'b1;
    bus.base_addr = 10'(base);
    bus.shift_amt = 5'(shift);
    start_cyc = cyc;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk);
      #1;
      bus.start = (c == extra);
      if (c == extra) bus.base_addr = 10'($urandom);
    end
  endtask

  task automatic run_job(input int base, input int shift);
    clear_caps();
    @(posedge clk);
    #1;
    job_body(base, shift, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.shift_amt = '0;
    fill_rows(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_wen", 64'(bus.sram_wen), 64'd1);
    check("rst_waddr", 64'(bus.sram_waddr), 64'd0);
    check("rst_wdata0", 64'(bus.sram_wdata0), 64'd0);
    check("rst_wdata1", 64'(bus.sram_wdata1), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_index", 64'(bus.matrix_index), 64'd0);
    srstn = 1'b1;

    // Basic drain with literal timing.
    fill_rows(1, 2, 3, 4, 5, 6, 7, 8);
    run_job(10'h040, 0);
    check("basic_wr_cnt", 64'(wr_cnt), 64'd8);
    check("basic_done_cnt", 64'(done_cnt), 64'd1);
    check("basic_d0", 64'(first_d0), 64'h01020304);
    check("basic_d1", 64'(first_d1), 64'h05060708);
    check("basic_addr_first", 64'(addr_q[0]), 64'h040);
    check("basic_addr_last", 64'(addr_q[7]), 64'h047);
    check("basic_first_wr_cyc", 64'(first_wr_cyc - start_cyc), 64'd2);
    check("basic_last_wr_cyc", 64'(last_wr_cyc - start_cyc), 64'd9);
    check("basic_done_cyc", 64'(done_cyc - start_cyc), 64'd10);

    // Rounding.
    fill_rows(24, 23, -24, -25, 1000, -1000, 21'h0FFFFF, 0);
    run_job(10'h000, 4);
    check("round_d0", 64'(first_d0), 64'h0201FFFE);
    check("round_d1", 64'(first_d1), 64'h3FC27F00);

    // Saturation at shift 0 and shift 8.
    fill_rows(1000, -1000, 5, -5, 127, -128, 128, -129);
    run_job(10'h010, 0);
    check("sat0_d0", 64'(first_d0), 64'h7F8005FB);
    check("sat0_d1", 64'(first_d1), 64'h7F807F80);
    fill_rows(21'h0FFFFF, -1048576, 384, -384, 128, -128, 127, 0);
    run_job(10'h020, 8);
    check("sat8_d0", 64'(first_d0), 64'h7F8002FF);
    check("sat8_d1", 64'(first_d1), 64'h01000000);

    // Shift past the accumulator width leaves only the sign.
    fill_rows(5, -5, 0, -1, 21'h0FFFFF, -1048576, 1, -1);
    run_job(10'h030, 25);
    check("bigshift_d0", 64'(first_d0), 64'h00FF00FF);
    check("bigshift_d1", 64'(first_d1), 64'h00FF00FF);

    // Start while busy is ignored; start in cycle 11 begins a new job.
    fill_random();
    clear_caps();
    @(posedge clk);
    #1;
    job_body(10'h080, 3, 4);
    check("busy_start_wr_cnt", 64'(wr_cnt), 64'd8);
    check("busy_start_done_cnt", 64'(done_cnt), 64'd1);
    clear_caps();
    job_body(10'h100, 2, 0);
    check("chain_wr_cnt", 64'(wr_cnt), 64'd8);
    check("chain_addr_first", 64'(addr_q[0]), 64'h100);
    check("chain_done_cyc", 64'(done_cyc - start_cyc), 64'd10);

    // Reset mid-job.
    clear_caps();
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base_addr = 10'h200;
    bus.shift_amt = 5'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    srstn = 1'b0;
    #1;
    check("midrst_wen", 64'(bus.sram_wen), 64'd1);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    srstn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_wr_cnt", 64'(wr_cnt), 64'd3);
    check("midrst_done_cnt", 64'(done_cnt), 64'd0);
    run_job(10'h300, 6);
    check("postrst_wr_cnt", 64'(wr_cnt), 64'd8);
    check("postrst_done_cnt", 64'(done_cnt), 64'd1);

    // Address wrap.
    run_job(10'h3FC, 0);
    begin
      int exp_a[8];
      exp_a = '{10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002, 10'h003};
      check("wrap_wr_cnt", 64'(addr_q.size()), 64'd8);
      for (int i = 0; i < 8 && i < addr_q.size(); i++)
        check("wrap_addr", 64'(addr_q[i]), 64'(exp_a[i]));
    end

    // Randomized jobs, with occasional ignored start pulses mid-job.
    for (int n = 0; n < 25; n++) begin
      fill_random();
      clear_caps();
      @(posedge clk);
      #1;
      job_body(int'($urandom_range(0, 1023)), int'($urandom_range(0, 31)),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 9)) : 0);
      check("rand_wr_cnt", 64'(wr_cnt), 64'd8);
      check("rand_done_cnt", 64'(done_cnt), 64'd1);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
